ecc_result_collector: RTL and testbench
=======================================

# ecc_result_collector

Serial-to-parallel result collector placed directly downstream of the ECC serial I/O wrapper. Captures the two MSB-first serial result streams (mP and mnP, each an x/y bit pair qualified by a valid strobe), reassembles them into right-justified `MAX_BITS` words according to the operand width mode, and hands each point to the host-side consumer over a valid/ready handshake. Also flags malformed bursts (short or overlapping) in sticky status bits.

## Interface
- `MAX_BITS`, 256: maximum operand width; sets the output word width.
- `CNT_W`, 9: bit-counter width; must hold `MAX_BITS`.
- `clk` in 1: the block's only clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `i_mode` in 2: width code (0=32, 1=64, 2=128, 3=256 bits). Sampled only on the first bit of each burst.
- `i_mP_valid` in 1: serial mP burst strobe.
- `i_mPx`, `i_mPy` in 1: mP coordinate bits, MSB first.
- `i_mnP_valid` in 1: serial mnP burst strobe.
- `i_mnPx`, `i_mnPy` in 1: mnP coordinate bits, MSB first.
- `o_mP_valid` out 1: parallel mP result available.
- `i_mP_ready` in 1: consumer accepts mP.
- `o_mPx`, `o_mPy` out MAX_BITS: assembled mP coordinates, zero-extended.
- `o_mnP_valid`, `i_mnP_ready`, `o_mnPx`, `o_mnPy`: the same set for the mnP channel.
- `o_err` out 4: sticky status. [0] mP short, [1] mP overrun, [2] mnP short, [3] mnP overrun.
- `i_err_clr` in 1: clears all `o_err` bits at the next edge.

## Operation
- Two identical, independent channels. Each channel has three states: IDLE, RECV, HOLD.
- Burst length N is 32, 64, 128 or 256, taken from `i_mode` on the burst's first bit and latched for the rest of the burst.
- IDLE:
  - If strobe=1, go to RECV with count=1.
  - Words are loaded as {0…, bitx} and {0…, bity}; the previous contents are discarded.
- RECV:
  - If strobe=1: shift in, word = {word[MAX_BITS-2:0], bit}, and increment count.
  - When the incoming bit is bit N-1 (count==N-1 before the shift), go to HOLD.
  - If strobe=0 before N bits: set the short error bit, go to IDLE, and keep `o_valid` low.
- HOLD:
  - `o_valid`=1 and the words are stable.
  - If valid&&ready: go to IDLE.
  - If strobe=1 while in HOLD without a same-cycle handoff: set the overrun error bit, drop the bit, and leave the held words unchanged. Further bits of that burst are also dropped; the channel stays in HOLD.
  - If the handoff and strobe=1 happen in the same cycle: complete the handoff and treat the bit as the first bit of a new burst (go to RECV, count=1). No error.
- Words above bit N-1 are always 0.
- `o_err` bits are set-only. `i_err_clr` clears them. If clear and set happen in the same cycle, set wins.
- Synchronous reset, including mid-burst: all states go to IDLE, counts to 0, all words to 0, `o_*_valid`=0, `o_err`=0. Bits arriving during reset are ignored.

## Timing
- Bit k of a burst is sampled on edge k (k=0..N-1).
- `o_valid` rises on the cycle after the last bit's cycle, i.e. 1-cycle latency after the final serial bit.
- Minimum spacing between accepted bursts is N+1 cycles with ready held high. Back-to-back bursts (strobe low for 0 cycles) are legal only via the same-cycle handoff case.
- `o_valid` and the data hold until ready. The consumer may hold ready high permanently.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared `ECCDefine.vh` holds:
  - `MAX_BITS` and the mode codes `BITS32`/`BITS64`/`BITS128`/`BITS256`.
  - A mode-to-length mapping macro/function returning N.
- The state encodings (IDLE/RECV/HOLD) are local to the sub-module.
- Sub-module `ecc_deser_channel`: one FSM, counter, two shift words and two error outputs. It is instantiated twice (mP, mnP).
- The top level holds only the instances and the sticky `o_err`/clear logic.

## Test plan
- Mode 0, mP burst 0xDEADBEEF / 0x12345678 → `o_mP_valid` asserted the cycle after bit 31; `o_mPx`=…0DEADBEEF, `o_mPy`=…012345678, upper 224 bits 0. Holds until the ready pulse, then deasserts the next cycle.
- Mode 3, both channels simultaneously, 256-bit patterns (0xA5 repeated for mP, 0x5A repeated for mnP) → both valid on cycle 256 with exact words; independent readies release each channel separately.
- Mode 1, strobe drops after 20 bits → `o_err`[0]=1, no valid. A following correct 64-bit burst of 0x1 is delivered as value 1.
- Channel in HOLD with ready=0, a new 32-bit burst arrives → `o_err`[1]=1, held words unchanged. `i_err_clr` then clears `o_err` to 0.
- Ready=1 in the final cycle of HOLD while the next burst's first bit arrives → no error; the second word is delivered correctly N cycles later.
- Reset asserted on bit 100 of a 128-bit burst → next cycle all outputs are 0; the channel accepts a fresh burst immediately after release.

Source files
------------

// File: rtl/ecc_result_collector_pkg.sv
// rtl/ecc_result_collector_pkg.sv - shared widths, mode codes and mode-to-length mapping
package ecc_result_collector_pkg;

   localparam int MAX_BITS = 256;
   localparam int CNT_W    = 9;

   localparam logic [1:0] BITS32  = 2'd0;
   localparam logic [1:0] BITS64  = 2'd1;
   localparam logic [1:0] BITS128 = 2'd2;
   localparam logic [1:0] BITS256 = 2'd3;

   function automatic logic [CNT_W-1:0] mode_len(input logic [1:0] mode);
      logic [CNT_W-1:0] len;
      case (mode)
         BITS32:  len = 9'd32;
         BITS64:  len = 9'd64;
         BITS128: len = 9'd128;
         default: len = 9'd256;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/ecc_result_collector_if.sv
// rtl/ecc_result_collector_if.sv - serial result inputs, parallel handshake outputs and status
interface ecc_result_collector_if #(
   parameter int MAX_BITS = 256
);
   logic [1:0]          i_mode;
   logic                i_mP_valid;
   logic                i_mPx;
   logic                i_mPy;
   logic                i_mnP_valid;
   logic                i_mnPx;
   logic                i_mnPy;
   logic                o_mP_valid;
   logic                i_mP_ready;
   logic [MAX_BITS-1:0] o_mPx;
   logic [MAX_BITS-1:0] o_mPy;
   logic                o_mnP_valid;
   logic                i_mnP_ready;
   logic [MAX_BITS-1:0] o_mnPx;
   logic [MAX_BITS-1:0] o_mnPy;
   logic [3:0]          o_err;
   logic                i_err_clr;

   modport master (
      output i_mode, i_mP_valid, i_mPx, i_mPy, i_mnP_valid, i_mnPx, i_mnPy,
             i_mP_ready, i_mnP_ready, i_err_clr,
      input  o_mP_valid, o_mPx, o_mPy, o_mnP_valid, o_mnPx, o_mnPy, o_err
   );

   modport slave (
      input  i_mode, i_mP_valid, i_mPx, i_mPy, i_mnP_valid, i_mnPx, i_mnPy,
             i_mP_ready, i_mnP_ready, i_err_clr,
      output o_mP_valid, o_mPx, o_mPy, o_mnP_valid, o_mnPx, o_mnPy, o_err
   );
endinterface

// File: rtl/ecc_result_collector_deser.sv
// rtl/ecc_result_collector_deser.sv - one serial-to-parallel channel: IDLE/RECV/HOLD FSM
module ecc_deser_channel
   import ecc_result_collector_pkg::*;
#(
   parameter int MAX_BITS = 256,
   parameter int CNT_W    = 9
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          mode_i,
   input  logic                strobe_i,
   input  logic                bit_x_i,
   input  logic                bit_y_i,
   input  logic                ready_i,
   output logic                valid_o,
   output logic [MAX_BITS-1:0] word_x_o,
   output logic [MAX_BITS-1:0] word_y_o,
   output logic                short_o,
   output logic                overrun_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_HOLD} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    len_q, len_d;
   logic [MAX_BITS-1:0] wx_q, wx_d;
   logic [MAX_BITS-1:0] wy_q, wy_d;
   logic                start;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         wx_q    <= '0;
         wy_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         wx_q    <= wx_d;
         wy_q    <= wy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      wx_d      = wx_q;
      wy_d      = wy_q;
      short_o   = 1'b0;
      overrun_o = 1'b0;
      start     = 1'b0;
      case (state_q)
         ST_IDLE: start = strobe_i;
         ST_RECV: begin
            if (strobe_i) begin
               wx_d  = {wx_q[MAX_BITS-2:0], bit_x_i};
               wy_d  = {wy_q[MAX_BITS-2:0], bit_y_i};
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == len_q - CNT_W'(1)) state_d = ST_HOLD;
            end else begin
               short_o = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            // A bit arriving in the handoff cycle opens the next burst instead of overrunning
            if (ready_i) begin
               if (strobe_i) begin
                  start = 1'b1;
               end else begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end
            end else if (strobe_i) begin
               overrun_o = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (start) begin
         state_d = ST_RECV;
         cnt_d   = CNT_W'(1);
         len_d   = CNT_W'(mode_len(mode_i));
         wx_d    = {{(MAX_BITS-1){1'b0}}, bit_x_i};
         wy_d    = {{(MAX_BITS-1){1'b0}}, bit_y_i};
      end
   end

   assign valid_o  = (state_q == ST_HOLD);
   assign word_x_o = wx_q;
   assign word_y_o = wy_q;

endmodule

// File: rtl/ecc_result_collector.sv
// rtl/ecc_result_collector.sv - two deserialiser channels (mP, mnP) plus sticky error status
module ecc_result_collector
   import ecc_result_collector_pkg::*;
#(
   parameter int MAX_BITS = ecc_result_collector_pkg::MAX_BITS,
   parameter int CNT_W    = ecc_result_collector_pkg::CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   ecc_result_collector_if.slave bus
);

   logic       mp_short, mp_ovr, mnp_short, mnp_ovr;
   logic [3:0] err_q, err_d;

   ecc_deser_channel #(.MAX_BITS(MAX_BITS), .CNT_W(CNT_W)) u_mp (
      .clk       (clk),
      .rst       (rst),
      .mode_i    (bus.i_mode),
      .strobe_i  (bus.i_mP_valid),
      .bit_x_i   (bus.i_mPx),
      .bit_y_i   (bus.i_mPy),
      .ready_i   (bus.i_mP_ready),
      .valid_o   (bus.o_mP_valid),
      .word_x_o  (bus.o_mPx),
      .word_y_o  (bus.o_mPy),
      .short_o   (mp_short),
      .overrun_o (mp_ovr)
   );

   ecc_deser_channel #(.MAX_BITS(MAX_BITS), .CNT_W(CNT_W)) u_mnp (
      .clk       (clk),
      .rst       (rst),
      .mode_i    (bus.i_mode),
      .strobe_i  (bus.i_mnP_valid),
      .bit_x_i   (bus.i_mnPx),
      .bit_y_i   (bus.i_mnPy),
      .ready_i   (bus.i_mnP_ready),
      .valid_o   (bus.o_mnP_valid),
      .word_x_o  (bus.o_mnPx),
      .word_y_o  (bus.o_mnPy),
      .short_o   (mnp_short),
      .overrun_o (mnp_ovr)
   );

   // New events are OR-ed in after the clear so a same-cycle set survives
   always_comb begin
      err_d = bus.i_err_clr ? 4'b0000 : err_q;
      err_d = err_d | {mnp_ovr, mnp_short, mp_ovr, mp_short};
   end

   always_ff @(posedge clk) begin
      if (!rst) err_q <= 4'b0000;
      else      err_q <= err_d;
   end

   assign bus.o_err = err_q;

endmodule

// File: tb/tb_ecc_result_collector.sv
// tb/tb_ecc_result_collector.sv - randomized self-checking bench for ecc_result_collector
module tb_ecc_result_collector;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   ecc_result_collector_if #(.MAX_BITS(256)) bus ();

   ecc_result_collector #(.MAX_BITS(256), .CNT_W(9)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic int len_of(input logic [1:0] mode);
      return 32 << mode;
   endfunction

   function automatic logic [255:0] masked(input logic [255:0] d, input int n);
      logic [255:0] one;
      one = 256'd1;
      if (n >= 256) return d;
      return d & ((one << n) - 256'd1);
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.i_mP_valid  = 1'b0;
      bus.i_mPx       = 1'b0;
      bus.i_mPy       = 1'b0;
      bus.i_mnP_valid = 1'b0;
      bus.i_mnPx      = 1'b0;
      bus.i_mnPy      = 1'b0;
   endtask

   // Drives the first nsend bits (MSB first) of N-bit words; counts valid-high cycles before the last bit
   task automatic send(input logic [1:0] mode, input int nsend, input bit en_p, input bit en_n,
                       input logic [255:0] px, input logic [255:0] py,
                       input logic [255:0] nx, input logic [255:0] ny,
                       output int vp_hi, output int vn_hi);
      int n;
      n = len_of(mode);
      vp_hi = 0;
      vn_hi = 0;
      for (int k = 0; k < nsend; k++) begin
         bus.i_mode      = mode;
         bus.i_mP_valid  = en_p;
         bus.i_mPx       = en_p & px[n-1-k];
         bus.i_mPy       = en_p & py[n-1-k];
         bus.i_mnP_valid = en_n;
         bus.i_mnPx      = en_n & nx[n-1-k];
         bus.i_mnPy      = en_n & ny[n-1-k];
         tick();
         if (k < nsend - 1) begin
            if (bus.o_mP_valid)  vp_hi++;
            if (bus.o_mnP_valid) vn_hi++;
         end
      end
      quiet();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.i_mode = 2'd0;
      bus.i_mP_ready = 1'b0;
      bus.i_mnP_ready = 1'b0;
      bus.i_err_clr = 1'b0;
      bus.i_mP_valid = 1'b1;
      bus.i_mnP_valid = 1'b1;
      bus.i_mPx = 1'b1;
      bus.i_mPy = 1'b1;
      bus.i_mnPx = 1'b1;
      bus.i_mnPy = 1'b1;
      repeat (3) tick();
      n_checks++;
      if ({bus.o_mP_valid, bus.o_mnP_valid, bus.o_err} !== 6'd0) $display("FAIL reset_ctrl got %b want 0", {bus.o_mP_valid, bus.o_mnP_valid, bus.o_err});
      else n_pass++;
      n_checks++;
      if ((bus.o_mPx | bus.o_mPy | bus.o_mnPx | bus.o_mnPy) !== 256'd0) $display("FAIL reset_words got nonzero want 0");
      else n_pass++;
      quiet();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_mode0();
      int vp, vn;
      logic [255:0] ex, ey;
      ex = 256'hDEADBEEF;
      ey = 256'h12345678;
      send(2'd0, 32, 1, 0, ex, ey, '0, '0, vp, vn);
      n_checks++;
      if (vp !== 0) $display("FAIL m0_early_valid got %0d want 0", vp);
      else n_pass++;
      n_checks++;
      if (bus.o_mP_valid !== 1'b1 || bus.o_mPx !== ex || bus.o_mPy !== ey)
         $display("FAIL m0_data got v=%b x=%h y=%h want 1 %h %h", bus.o_mP_valid, bus.o_mPx, bus.o_mPy, ex, ey);
      else n_pass++;
      repeat (4) tick();
      n_checks++;
      if (bus.o_mP_valid !== 1'b1 || bus.o_mPx !== ex || bus.o_mPy !== ey) $display("FAIL m0_hold got v=%b x=%h", bus.o_mP_valid, bus.o_mPx);
      else n_pass++;
      bus.i_mP_ready = 1'b1;
      tick();
      bus.i_mP_ready = 1'b0;
      n_checks++;
      if (bus.o_mP_valid !== 1'b0) $display("FAIL m0_release got %b want 0", bus.o_mP_valid);
      else n_pass++;
   endtask

   task automatic test_mode3_both();
      int vp, vn;
      logic [255:0] a, b;
      a = {32{8'hA5}};
      b = {32{8'h5A}};
      send(2'd3, 256, 1, 1, a, ~a, b, ~b, vp, vn);
      n_checks++;
      if (vp !== 0 || vn !== 0) $display("FAIL m3_early_valid got %0d/%0d want 0/0", vp, vn);
      else n_pass++;
      n_checks++;
      if (bus.o_mP_valid !== 1'b1 || bus.o_mPx !== a || bus.o_mPy !== ~a) $display("FAIL m3_mp got v=%b x=%h want 1 %h", bus.o_mP_valid, bus.o_mPx, a);
      else n_pass++;
      n_checks++;
      if (bus.o_mnP_valid !== 1'b1 || bus.o_mnPx !== b || bus.o_mnPy !== ~b) $display("FAIL m3_mnp got v=%b x=%h want 1 %h", bus.o_mnP_valid, bus.o_mnPx, b);
      else n_pass++;
      bus.i_mP_ready = 1'b1;
      tick();
      bus.i_mP_ready = 1'b0;
      n_checks++;
      if (bus.o_mP_valid !== 1'b0 || bus.o_mnP_valid !== 1'b1 || bus.o_mnPx !== b) $display("FAIL m3_indep got mp=%b mnp=%b want 0 1", bus.o_mP_valid, bus.o_mnP_valid);
      else n_pass++;
      bus.i_mnP_ready = 1'b1;
      tick();
      bus.i_mnP_ready = 1'b0;
      n_checks++;
      if (bus.o_mnP_valid !== 1'b0) $display("FAIL m3_mnp_release got %b want 0", bus.o_mnP_valid);
      else n_pass++;
   endtask

   task automatic test_short();
      int vp, vn;
      send(2'd1, 20, 1, 0, rand256(), rand256(), '0, '0, vp, vn);
      repeat (3) tick();
      n_checks++;
      if (bus.o_err !== 4'b0001 || bus.o_mP_valid !== 1'b0) $display("FAIL short_err got err=%b v=%b want 0001 0", bus.o_err, bus.o_mP_valid);
      else n_pass++;
      send(2'd1, 64, 1, 0, 256'd1, 256'd1, '0, '0, vp, vn);
      n_checks++;
      if (bus.o_mP_valid !== 1'b1 || bus.o_mPx !== 256'd1 || bus.o_mPy !== 256'd1) $display("FAIL short_recover got v=%b x=%h want 1 1", bus.o_mP_valid, bus.o_mPx);
      else n_pass++;
      bus.i_mP_ready = 1'b1;
      bus.i_err_clr = 1'b1;
      tick();
      bus.i_mP_ready = 1'b0;
      bus.i_err_clr = 1'b0;
      n_checks++;
      if (bus.o_err !== 4'b0000 || bus.o_mP_valid !== 1'b0) $display("FAIL short_clear got err=%b v=%b want 0000 0", bus.o_err, bus.o_mP_valid);
      else n_pass++;
   endtask

   task automatic test_overrun();
      int vp, vn;
      logic [255:0] ax, ay;
      ax = masked(rand256(), 32);
      ay = masked(rand256(), 32);
      send(2'd0, 32, 0, 1, '0, '0, ax, ay, vp, vn);
      send(2'd0, 32, 0, 1, '0, '0, rand256(), rand256(), vp, vn);
      n_checks++;
      if (vn !== 31 || bus.o_mnP_valid !== 1'b1) $display("FAIL ovr_valid got %0d v=%b want 31 1", vn, bus.o_mnP_valid);
      else n_pass++;
      n_checks++;
      if (bus.o_err !== 4'b1000) $display("FAIL ovr_err got %b want 1000", bus.o_err);
      else n_pass++;
      n_checks++;
      if (bus.o_mnPx !== ax || bus.o_mnPy !== ay) $display("FAIL ovr_held got x=%h want %h", bus.o_mnPx, ax);
      else n_pass++;
      bus.i_err_clr = 1'b1;
      tick();
      bus.i_err_clr = 1'b0;
      n_checks++;
      if (bus.o_err !== 4'b0000) $display("FAIL ovr_clear got %b want 0000", bus.o_err);
      else n_pass++;
      bus.i_err_clr = 1'b1;
      bus.i_mnP_valid = 1'b1;
      tick();
      quiet();
      bus.i_err_clr = 1'b0;
      n_checks++;
      if (bus.o_err !== 4'b1000) $display("FAIL set_beats_clear got %b want 1000", bus.o_err);
      else n_pass++;
      bus.i_err_clr = 1'b1;
      bus.i_mnP_ready = 1'b1;
      tick();
      bus.i_err_clr = 1'b0;
      bus.i_mnP_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int vp, vn;
      logic [255:0] ax, ay, cx, cy;
      ax = masked(rand256(), 32);
      ay = masked(rand256(), 32);
      cx = masked(rand256(), 32);
      cy = masked(rand256(), 32);
      bus.i_mP_ready = 1'b1;
      send(2'd0, 32, 1, 0, ax, ay, '0, '0, vp, vn);
      n_checks++;
      if (bus.o_mP_valid !== 1'b1 || bus.o_mPx !== ax || bus.o_mPy !== ay) $display("FAIL b2b_first got x=%h want %h", bus.o_mPx, ax);
      else n_pass++;
      send(2'd0, 32, 1, 0, cx, cy, '0, '0, vp, vn);
      n_checks++;
      if (vp !== 0 || bus.o_mP_valid !== 1'b1 || bus.o_mPx !== cx || bus.o_mPy !== cy) $display("FAIL b2b_second got vp=%0d x=%h want 0 %h", vp, bus.o_mPx, cx);
      else n_pass++;
      n_checks++;
      if (bus.o_err !== 4'b0000) $display("FAIL b2b_err got %b want 0000", bus.o_err);
      else n_pass++;
      tick();
      bus.i_mP_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int vp, vn;
      logic [255:0] ax, ay;
      send(2'd2, 100, 1, 1, rand256(), rand256(), rand256(), rand256(), vp, vn);
      rst = 1'b0;
      bus.i_mP_valid = 1'b1;
      bus.i_mnP_valid = 1'b1;
      tick();
      quiet();
      n_checks++;
      if ({bus.o_mP_valid, bus.o_mnP_valid, bus.o_err} !== 6'd0 ||
          (bus.o_mPx | bus.o_mPy | bus.o_mnPx | bus.o_mnPy) !== 256'd0) $display("FAIL midreset got v=%b%b err=%b want 0", bus.o_mP_valid, bus.o_mnP_valid, bus.o_err);
      else n_pass++;
      rst = 1'b1;
      ax = masked(rand256(), 32);
      ay = masked(rand256(), 32);
      send(2'd0, 32, 1, 0, ax, ay, '0, '0, vp, vn);
      n_checks++;
      if (bus.o_mP_valid !== 1'b1 || bus.o_mPx !== ax || bus.o_mPy !== ay) $display("FAIL midreset_fresh got x=%h want %h", bus.o_mPx, ax);
      else n_pass++;
      bus.i_mP_ready = 1'b1;
      tick();
      bus.i_mP_ready = 1'b0;
   endtask

   task automatic test_random();
      int vp, vn, n, gap;
      logic [1:0] mode;
      logic [1:0] en;
      logic [255:0] px, py, nx, ny;
      bus.i_mP_ready = 1'b1;
      bus.i_mnP_ready = 1'b1;
      for (int it = 0; it < 12; it++) begin
         mode = 2'($urandom_range(0, 3));
         en   = 2'($urandom_range(1, 3));
         n    = len_of(mode);
         px = rand256(); py = rand256(); nx = rand256(); ny = rand256();
         send(mode, n, en[0], en[1], px, py, nx, ny, vp, vn);
         n_checks++;
         if (bus.o_mP_valid !== en[0] || (en[0] && (bus.o_mPx !== masked(px, n) || bus.o_mPy !== masked(py, n))))
            $display("FAIL rand_mp it=%0d n=%0d got v=%b x=%h want v=%b x=%h", it, n, bus.o_mP_valid, bus.o_mPx, en[0], masked(px, n));
         else n_pass++;
         n_checks++;
         if (bus.o_mnP_valid !== en[1] || (en[1] && (bus.o_mnPx !== masked(nx, n) || bus.o_mnPy !== masked(ny, n))))
            $display("FAIL rand_mnp it=%0d n=%0d got v=%b x=%h want v=%b x=%h", it, n, bus.o_mnP_valid, bus.o_mnPx, en[1], masked(nx, n));
         else n_pass++;
         n_checks++;
         if (vp !== 0 || vn !== 0 || bus.o_err !== 4'b0000) $display("FAIL rand_side it=%0d got vp=%0d vn=%0d err=%b want 0 0 0000", it, vp, vn, bus.o_err);
         else n_pass++;
         gap = $urandom_range(0, 2);
         repeat (gap) tick();
      end
      tick();
      bus.i_mP_ready = 1'b0;
      bus.i_mnP_ready = 1'b0;
   endtask

   initial begin
      quiet();
      test_reset();
      test_mode0();
      test_mode3_both();
      test_short();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
